// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: sequences start, data, optional parity and stop
// bits, one frame bit per CLK, and drives the line-source select for an
// external output mux. All outputs are registered.
// Optional feature macro: UART_TX_PARITY_EN (parity bit support). When it is
// undefined the parity state is absent, PAR_EN/PAR_TYP are ignored and
// PAR_BIT is held at 0.

module uart_tx_ctrl #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  SER_DATA,
    output logic                  PAR_BIT,
    output logic [1:0]            MUX_SEL,
    output logic                  BUSY
);

    localparam logic [1:0] SEL_START  = 2'b00;
    localparam logic [1:0] SEL_DATA   = 2'b01;
`ifdef UART_TX_PARITY_EN
    localparam logic [1:0] SEL_PARITY = 2'b10;
`endif
    localparam logic [1:0] SEL_STOP   = 2'b11;

    localparam logic [2:0] LAST_BIT = 3'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [2:0]            bit_cnt;

`ifdef UART_TX_PARITY_EN
    logic                  par_en_q;
`else
    logic                  unused_cfg;

    assign unused_cfg = PAR_EN ^ PAR_TYP;
    assign PAR_BIT    = 1'b0;
`endif

    // Frame sequencer; outputs are computed from the next state so they
    // line up with the state register.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            MUX_SEL   <= SEL_STOP;
            BUSY      <= 1'b0;
            SER_DATA  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= 1'b0;
            PAR_BIT   <= 1'b0;
`endif
        end else begin
            case (state)
                // STOP shares the IDLE decision so a request in the stop
                // cycle starts the next frame with no idle gap.
                IDLE, STOP: begin
                    if (DATA_VALID) begin
                        state     <= START;
                        shift_reg <= P_DATA;
                        MUX_SEL   <= SEL_START;
                        BUSY      <= 1'b1;
                        SER_DATA  <= 1'b0;
`ifdef UART_TX_PARITY_EN
                        par_en_q  <= PAR_EN;
                        PAR_BIT   <= (^P_DATA) ^ PAR_TYP;
`endif
                    end else begin
                        state    <= IDLE;
                        MUX_SEL  <= SEL_STOP;
                        BUSY     <= 1'b0;
                        SER_DATA <= 1'b0;
                    end
                end
                START: begin
                    state     <= DATA;
                    bit_cnt   <= '0;
                    MUX_SEL   <= SEL_DATA;
                    SER_DATA  <= shift_reg[0];
                    shift_reg <= shift_reg >> 1;
                end
                DATA: begin
                    if (bit_cnt == LAST_BIT) begin
                        SER_DATA <= 1'b0;
`ifdef UART_TX_PARITY_EN
                        if (par_en_q) begin
                            state   <= PARITY;
                            MUX_SEL <= SEL_PARITY;
                        end else begin
                            state   <= STOP;
                            MUX_SEL <= SEL_STOP;
                        end
`else
                        state   <= STOP;
                        MUX_SEL <= SEL_STOP;
`endif
                    end else begin
                        bit_cnt   <= bit_cnt + 3'd1;
                        SER_DATA  <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    state   <= STOP;
                    MUX_SEL <= SEL_STOP;
                end
`endif
                default: begin
                    state    <= IDLE;
                    MUX_SEL  <= SEL_STOP;
                    BUSY     <= 1'b0;
                    SER_DATA <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: the stimulus process pushes one expected
// output record per clock; a monitor pops and compares at each falling edge.
// Expected parity values are hand-computed per vector; builds without
// UART_TX_PARITY_EN expect no parity cycle and PAR_BIT = 0.

module tb_uart_tx_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] P_DATA = '0;
    logic       DATA_VALID = 1'b1;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       SER_DATA;
    logic       PAR_BIT;
    logic [1:0] MUX_SEL;
    logic       BUSY;

    uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .SER_DATA   (SER_DATA),
        .PAR_BIT    (PAR_BIT),
        .MUX_SEL    (MUX_SEL),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0] mux;
        logic       busy;
        logic       ser;
        logic       ser_care;
        logic       par;
        logic       par_care;
        int         vec;
        int         phase;   // 0 idle, 1 start, 2 data, 3 parity, 4 stop, 5 reset
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   vec_id = 0;

    // Monitor: one expected record per clock, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (q.size() > 0) begin
                e = q.pop_front();
                vectors++;
                if (MUX_SEL !== e.mux) begin
                    miscompares++;
                    $display("FAIL mux v%0d ph%0d got %b want %b", e.vec, e.phase, MUX_SEL, e.mux);
                end
                if (BUSY !== e.busy) begin
                    miscompares++;
                    $display("FAIL busy v%0d ph%0d got %b want %b", e.vec, e.phase, BUSY, e.busy);
                end
                if (e.ser_care && SER_DATA !== e.ser) begin
                    miscompares++;
                    $display("FAIL ser v%0d ph%0d got %b want %b", e.vec, e.phase, SER_DATA, e.ser);
                end
                if (e.par_care && PAR_BIT !== e.par) begin
                    miscompares++;
                    $display("FAIL par v%0d ph%0d got %b want %b", e.vec, e.phase, PAR_BIT, e.par);
                end
            end
        end
    end

    // Drive inputs for the next rising edge and queue the outputs expected after it.
    task automatic step(input logic rst_n, input logic dv, input logic [7:0] d,
                        input logic pe, input logic pt, input logic [1:0] emux,
                        input logic ebusy, input logic eser, input logic sc,
                        input logic epar, input logic pc, input int ph);
        exp_t e;
        @(negedge CLK);
        #1;
        RST        = rst_n;
        DATA_VALID = dv;
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        e.mux = emux; e.busy = ebusy; e.ser = eser; e.ser_care = sc;
        e.par = epar; e.par_care = pc; e.vec = vec_id; e.phase = ph;
        q.push_back(e);
    endtask

    task automatic idle(input int n, input logic par_known, input logic epar);
        for (int i = 0; i < n; i++)
            step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1, epar, par_known, 0);
    endtask

    // One full frame; inputs are scrambled after the request to prove the
    // latched copy is used. glitch selects a data step that also pulses
    // DATA_VALID with 0xFF (-1 for none).
    task automatic frame(input logic [7:0] d, input logic pe, input logic pt,
                         input logic epar_hand, input int glitch);
        logic pe_eff;
        logic epar;
        logic dv_n;
        logic [7:0] d_n;
        vec_id++;
`ifdef UART_TX_PARITY_EN
        pe_eff = pe;
        epar   = epar_hand;
`else
        pe_eff = 1'b0;
        epar   = 1'b0;
`endif
        step(1'b1, 1'b1, d, pe, pt, 2'b00, 1'b1, 1'b0, 1'b0, epar, 1'b1, 1);
        for (int i = 0; i < 8; i++) begin
            dv_n = (i == glitch);
            d_n  = dv_n ? 8'hFF : ~d;
            step(1'b1, dv_n, d_n, ~pe, ~pt, 2'b01, 1'b1, d[i], 1'b1, epar, 1'b1, 2);
        end
        if (pe_eff)
            step(1'b1, 1'b0, ~d, ~pe, ~pt, 2'b10, 1'b1, 1'b0, 1'b0, epar, 1'b1, 3);
        step(1'b1, 1'b0, ~d, ~pe, ~pt, 2'b11, 1'b1, 1'b0, 1'b0, epar, 1'b1, 4);
    endtask

    initial begin
        logic [7:0] rd;
        // Reset with a concurrent request that must be ignored.
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5);
        idle(2, 1'b1, 1'b0);

        // 0xA5 no parity; then even and odd parity.
        frame(8'hA5, 1'b0, 1'b0, 1'b0, -1);
        idle(2, 1'b0, 1'b0);
        frame(8'hA5, 1'b1, 1'b0, 1'b0, -1);
        idle(1, 1'b0, 1'b0);
        frame(8'hA5, 1'b1, 1'b1, 1'b1, -1);
        idle(2, 1'b0, 1'b0);

        // Back-to-back: second request lands in the first frame's stop cycle.
        frame(8'h3C, 1'b1, 1'b0, 1'b0, -1);
        frame(8'hC3, 1'b0, 1'b0, 1'b0, -1);
        idle(2, 1'b0, 1'b0);

        // Request with 0xFF in the 3rd data cycle of a 0x00 frame: ignored.
        frame(8'h00, 1'b1, 1'b1, 1'b1, 3);
        idle(4, 1'b0, 1'b0);

        // Reset during the 5th data cycle of a 0x5A frame (odd parity = 1).
        vec_id++;
        rd = 8'h5A;
`ifdef UART_TX_PARITY_EN
        step(1'b1, 1'b1, rd, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'b01, 1'b1, rd[i], 1'b1, 1'b1, 1'b1, 2);
`else
        step(1'b1, 1'b1, rd, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'b01, 1'b1, rd[i], 1'b1, 1'b0, 1'b1, 2);
`endif
        step(1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5);
        idle(2, 1'b1, 1'b0);

        // Clean frame after reset: 0x07 even parity = 1.
        frame(8'h07, 1'b1, 1'b0, 1'b1, -1);
        idle(2, 1'b0, 1'b0);

        for (int i = 0; i < 10 && q.size() > 0; i++)
            @(negedge CLK);
        #2;
        if (q.size() > 0) begin
            miscompares++;
            $display("FAIL drain left %0d want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, 8, number of data bits per frame (legal 5..8).
REQ-002 SHALL have port: CLK  input  1  transmit bit-rate clock, one frame bit per cycle.
REQ-003 SHALL have port: RST  input  1  synchronous, active-low reset, sampled on rising CLK.
REQ-004 SHALL have port: P_DATA  input  DATA_WIDTH  parallel byte to transmit.
REQ-005 SHALL have port: DATA_VALID  input  1  P_DATA valid, single-cycle request.
REQ-006 SHALL have port: PAR_EN  input  1  parity bit inserted when 1.
REQ-007 SHALL have port: PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-008 SHALL have port: SER_DATA  output  1  current data bit, LSB first.
REQ-009 SHALL have port: PAR_BIT  output  1  parity of the latched byte.
REQ-010 SHALL have port: MUX_SEL  output  2  line-source select: 00 start, 01 data, 10 parity, 11 stop/idle.
REQ-011 SHALL have port: BUSY  output  1  high while a frame is in progress.
REQ-012 SHALL use CLK as the only clock; all outputs SHALL be registered.

Function
REQ-013 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; each START/PARITY/STOP state SHALL last exactly one CLK.
REQ-014 In IDLE, DATA_VALID=1 at edge k SHALL latch P_DATA, PAR_EN, PAR_TYP and enter START after edge k.
REQ-015 START SHALL drive MUX_SEL=00, BUSY=1; next state DATA.
REQ-016 DATA SHALL last DATA_WIDTH cycles, MUX_SEL=01, SER_DATA = latched bit i in cycle i (i=0 first), using a shift register and a 3-bit counter that resets to 0 on entering DATA.
REQ-017 After the last data bit: PARITY if latched PAR_EN=1, else STOP.
REQ-018 PARITY SHALL drive MUX_SEL=10; PAR_BIT = XOR of latched data (even) or its inverse (odd), stable from START to end of frame.
REQ-019 STOP SHALL drive MUX_SEL=11, BUSY=1; next state IDLE, or START if DATA_VALID=1 in the STOP cycle (back-to-back, no idle gap, new data latched).
REQ-020 IDLE SHALL drive MUX_SEL=11, BUSY=0, SER_DATA=0.
REQ-021 DATA_VALID while BUSY=1 and not in STOP SHALL be ignored; latched data and config SHALL NOT change mid-frame.
REQ-022 Frame length SHALL be 1 + DATA_WIDTH + PAR_EN + 1 cycles from START entry.
REQ-023 Changes of P_DATA/PAR_EN/PAR_TYP during a frame SHALL NOT affect that frame.

Reset
REQ-024 RST=0 at a rising CLK SHALL force IDLE from any state, including mid-frame, abandoning the frame.
REQ-025 Reset values: MUX_SEL=11, BUSY=0, SER_DATA=0, PAR_BIT=0, counter=0, shift register=0.
REQ-026 DATA_VALID in the same cycle as RST=0 SHALL be ignored.

Configuration
REQ-027 Macro UART_TX_PARITY_EN defined: parity SHALL behave per REQ-017/018.
REQ-028 Macro UART_TX_PARITY_EN undefined: PARITY state and parity logic SHALL be omitted, PAR_EN/PAR_TYP ignored, PAR_BIT tied 0, MUX_SEL never 10, frame = DATA_WIDTH+2 cycles.

Verification
REQ-029 P_DATA=0xA5, PAR_EN=0 -> MUX_SEL 00, 01x8, 11; SER_DATA 1,0,1,0,0,1,0,1; BUSY high 10 cycles.
REQ-030 P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 -> PARITY cycle with MUX_SEL=10, PAR_BIT=0; PAR_TYP=1 -> PAR_BIT=1; 11-cycle frame.
REQ-031 0x3C then 0xC3, DATA_VALID pulsed in the STOP cycle -> second START immediately follows STOP, BUSY never drops.
REQ-032 DATA_VALID with P_DATA=0xFF pulsed in the 3rd DATA cycle of a 0x00 frame -> frame bits all 0, no second frame.
REQ-033 RST=0 asserted in 5th DATA cycle -> next cycle MUX_SEL=11, BUSY=0, SER_DATA=0; new frame starts cleanly afterward.
REQ-034 Build without UART_TX_PARITY_EN, PAR_EN=1, 0xA5 -> no MUX_SEL=10, 10-cycle frame, PAR_BIT=0.
